// File: rtl/breath_pkg.sv
// Shared types and default widths for the LED breathing scheduler.
package breath_pkg;
    localparam int W_DEF  = 24;
    localparam int RW_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        RISE,
        HOLD_HI,
        FALL,
        HOLD_LO
    } state_e;
endpackage

// File: rtl/pwm_core.sv
// PWM period counter with registered compare output and a period-boundary pulse.
module pwm_core #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         active,
    input  logic         run,
    input  logic [W-1:0] period,
    input  logic [W-1:0] duty_nxt,
    output logic         boundary,
    output logic         out
);
    logic [W-1:0] cnt_q, cnt_d;
    logic         out_q, out_d;
    logic         wrap;

    assign wrap     = (cnt_q == period - W'(1));
    assign boundary = active && wrap;
    assign out      = out_q;

    // out is computed from the count and duty that will be live next cycle,
    // so the registered output lines up with the counter value it belongs to.
    always_comb begin
        cnt_d = '0;
        if (run && active && !wrap) begin
            cnt_d = cnt_q + W'(1);
        end
        out_d = run && (cnt_d < duty_nxt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end
endmodule

// File: rtl/breath_sched.sv
// Breathing-pattern scheduler: ramps PWM duty between a floor and a ceiling
// with optional holds, for a programmed number of breaths or until stopped.
module breath_sched
    import breath_pkg::*;
#(
    parameter int W  = W_DEF,
    parameter int RW = RW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [W-1:0]  period,
    input  logic [W-1:0]  duty_min,
    input  logic [W-1:0]  duty_max,
    input  logic [W-1:0]  step,
    input  logic [7:0]    div,
    input  logic [7:0]    hold_hi,
    input  logic [7:0]    hold_lo,
    input  logic [RW-1:0] reps,
    output logic          out,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [W-1:0]  duty
);
    state_e        state_q, state_d;
    logic [W-1:0]  period_q, dmin_q, dmax_q, step_q;
    logic [7:0]    div_q, hh_q, hl_q;
    logic [RW-1:0] reps_q;
    logic [W-1:0]  duty_q, duty_d;
    logic [7:0]    divc_q, divc_d;
    logic [7:0]    hcnt_q, hcnt_d;
    logic [RW-1:0] rep_q, rep_d;
    logic          done_q, done_d;
    logic          cfg_err_q, cfg_err_d;

    logic          bad_cfg, accept, reject;
    logic          boundary, tick, eob, last_rep;
    logic [7:0]    div_m1;
    logic [W:0]    sum;
    logic [W-1:0]  inc_v, dec_v;
    logic [RW:0]   rep_inc;

    assign bad_cfg = (period == '0) || (step == '0) || (duty_min > duty_max);
    assign accept  = (state_q == IDLE) && start && !stop && !bad_cfg;
    assign reject  = (state_q == IDLE) && start && !stop && bad_cfg;

    assign div_m1 = (div_q == 8'd0) ? 8'd0 : div_q - 8'd1;
    assign tick   = boundary && (divc_q == div_m1);

    // Saturating ramp arithmetic; the W+1-bit sum keeps a large step from wrapping.
    assign sum   = {1'b0, duty_q} + {1'b0, step_q};
    assign inc_v = (sum > {1'b0, dmax_q}) ? dmax_q : sum[W-1:0];
    assign dec_v = ((duty_q - dmin_q) <= step_q) ? dmin_q : duty_q - step_q;

    assign rep_inc  = {1'b0, rep_q} + {{RW{1'b0}}, 1'b1};
    assign last_rep = (reps_q != '0) && (rep_inc == {1'b0, reps_q});

    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        divc_d    = divc_q;
        hcnt_d    = hcnt_q;
        rep_d     = rep_q;
        done_d    = 1'b0;
        cfg_err_d = reject;
        eob       = 1'b0;

        if (boundary) begin
            divc_d = tick ? 8'd0 : divc_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = RISE;
                    duty_d  = duty_min;
                    divc_d  = 8'd0;
                    hcnt_d  = 8'd0;
                    rep_d   = '0;
                end
            end
            RISE: begin
                if (tick) begin
                    if (duty_q == dmax_q) begin
                        if (hh_q != 8'd0) begin
                            state_d = HOLD_HI;
                            hcnt_d  = 8'd0;
                        end else begin
                            state_d = FALL;
                            duty_d  = dec_v;
                        end
                    end else begin
                        duty_d = inc_v;
                    end
                end
            end
            HOLD_HI: begin
                if (tick) begin
                    if (hcnt_q + 8'd1 == hh_q) begin
                        state_d = FALL;
                        duty_d  = dec_v;
                    end else begin
                        hcnt_d = hcnt_q + 8'd1;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (duty_q == dmin_q) begin
                        if (hl_q != 8'd0) begin
                            state_d = HOLD_LO;
                            hcnt_d  = 8'd0;
                        end else begin
                            eob = 1'b1;
                        end
                    end else begin
                        duty_d = dec_v;
                    end
                end
            end
            HOLD_LO: begin
                if (tick) begin
                    if (hcnt_q + 8'd1 == hl_q) begin
                        eob = 1'b1;
                    end else begin
                        hcnt_d = hcnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (eob) begin
            if (last_rep) begin
                state_d = IDLE;
                duty_d  = '0;
                done_d  = 1'b1;
            end else begin
                state_d = RISE;
                duty_d  = inc_v;
                if (reps_q != '0) begin
                    rep_d = rep_inc[RW-1:0];
                end
            end
        end

        // Abort takes priority over everything, including a completing breath.
        if (stop && (state_q != IDLE)) begin
            state_d = IDLE;
            duty_d  = '0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            duty_q    <= '0;
            divc_q    <= '0;
            hcnt_q    <= '0;
            rep_q     <= '0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            duty_q    <= duty_d;
            divc_q    <= divc_d;
            hcnt_q    <= hcnt_d;
            rep_q     <= rep_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_q <= '0;
            dmin_q   <= '0;
            dmax_q   <= '0;
            step_q   <= '0;
            div_q    <= '0;
            hh_q     <= '0;
            hl_q     <= '0;
            reps_q   <= '0;
        end else if (accept) begin
            period_q <= period;
            dmin_q   <= duty_min;
            dmax_q   <= duty_max;
            step_q   <= step;
            div_q    <= div;
            hh_q     <= hold_hi;
            hl_q     <= hold_lo;
            reps_q   <= reps;
        end
    end

    pwm_core #(.W(W)) u_pwm (
        .clk      (clk),
        .rst      (rst),
        .active   (state_q != IDLE),
        .run      (state_d != IDLE),
        .period   (period_q),
        .duty_nxt (duty_d),
        .boundary (boundary),
        .out      (out)
    );

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign cfg_err = cfg_err_q;
    assign duty    = duty_q;
endmodule

// File: tb/tb_breath_sched.sv
// Bench for breath_sched: directed and random ramp configurations checked
// cycle by cycle against a tick-list model of the breathing pattern.
module tb_breath_sched;
    localparam int W  = 24;
    localparam int RW = 8;

    logic          clk, rst, start, stop;
    logic [W-1:0]  period, duty_min, duty_max, step;
    logic [7:0]    div, hold_hi, hold_lo;
    logic [RW-1:0] reps;
    logic          out, busy, done, cfg_err;
    logic [W-1:0]  duty;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] exp_q[$];
    logic         exp_out_q[$];
    int           exp_st_q[$];

    breath_sched #(.W(W), .RW(RW)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .stop     (stop),
        .period   (period),
        .duty_min (duty_min),
        .duty_max (duty_max),
        .step     (step),
        .div      (div),
        .hold_hi  (hold_hi),
        .hold_lo  (hold_lo),
        .reps     (reps),
        .out      (out),
        .busy     (busy),
        .done     (done),
        .cfg_err  (cfg_err),
        .duty     (duty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int per, mn, mx, st, dv, hh, hl, rp);
        period   = W'(per);
        duty_min = W'(mn);
        duty_max = W'(mx);
        step     = W'(st);
        div      = 8'(dv);
        hold_hi  = 8'(hh);
        hold_lo  = 8'(hl);
        reps     = RW'(rp);
    endtask

    // Model: list the duty of every step tick for nb breaths, then expand each
    // tick into div periods of per cycles with out high while cycle < duty.
    task automatic build(input longint per, mn, mx, st, input int dv, hh, hl, nb);
        longint t_d[$];
        int     t_s[$];
        longint d;
        int     dve;
        exp_q.delete();
        exp_out_q.delete();
        exp_st_q.delete();
        for (int b = 0; b < nb; b++) begin
            d = (b == 0) ? mn : ((mn + st > mx) ? mx : mn + st);
            t_d.push_back(d); t_s.push_back(b * 8 + 1);
            while (d != mx) begin
                d = (d + st > mx) ? mx : d + st;
                t_d.push_back(d); t_s.push_back(b * 8 + 1);
            end
            for (int k = 0; k < hh; k++) begin
                t_d.push_back(mx); t_s.push_back(b * 8 + 2);
            end
            d = mx;
            do begin
                d = (d - mn <= st) ? mn : d - st;
                t_d.push_back(d); t_s.push_back(b * 8 + 3);
            end while (d != mn);
            for (int k = 0; k < hl; k++) begin
                t_d.push_back(mn); t_s.push_back(b * 8 + 4);
            end
        end
        dve = (dv == 0) ? 1 : dv;
        foreach (t_d[k]) begin
            for (int r = 0; r < dve; r++) begin
                for (longint c = 0; c < per; c++) begin
                    exp_q.push_back(W'(t_d[k]));
                    exp_out_q.push_back(c < t_d[k]);
                    exp_st_q.push_back(t_s[k]);
                end
            end
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " busy"}, W'(busy), '0);
        chk({tag, " out"}, W'(out), '0);
        chk({tag, " done"}, W'(done), '0);
    endtask

    // Called at a negedge in IDLE with inputs set and the model built.
    task automatic run_seq(input string tag, input bit exp_done, input int stop_at,
                           input int poke_at, input int rst_at);
        start = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, " out"}, W'(out), W'(exp_out_q[i]));
            chk({tag, " duty"}, duty, exp_q[i]);
            chk({tag, " busy"}, W'(busy), W'(1));
            chk({tag, " done"}, W'(done), '0);
            chk({tag, " cfg_err"}, W'(cfg_err), '0);
            if (i == stop_at) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                chk_idle({tag, " after stop"});
                repeat (3) begin
                    @(negedge clk);
                    chk_idle({tag, " idle after stop"});
                end
                return;
            end
            if (i == rst_at) begin
                #1 rst = 1'b0;
                #1;
                chk({tag, " rst out"}, W'(out), '0);
                chk({tag, " rst busy"}, W'(busy), '0);
                chk({tag, " rst done"}, W'(done), '0);
                chk({tag, " rst cfg_err"}, W'(cfg_err), '0);
                chk({tag, " rst duty"}, duty, '0);
                @(negedge clk);
                chk_idle({tag, " in rst"});
                rst = 1'b1;
                return;
            end
            if (i == poke_at) begin
                start = 1'b1;
                cfg($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9),
                    $urandom_range(0, 9), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            end
        end
        if (exp_done) begin
            @(negedge clk);
            start = 1'b0;
            chk({tag, " done pulse"}, W'(done), W'(1));
            chk({tag, " busy at done"}, W'(busy), '0);
            chk({tag, " out at done"}, W'(out), '0);
            @(negedge clk);
            chk({tag, " done width"}, W'(done), '0);
            chk({tag, " busy after done"}, W'(busy), '0);
        end
    endtask

    initial begin
        int per, mn, mx, st, dv, hh, hl, rp, hi_at;
        rst = 1'b0;
        start = 1'b0;
        stop = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("reset out", W'(out), '0);
        chk("reset busy", W'(busy), '0);
        chk("reset done", W'(done), '0);
        chk("reset cfg_err", W'(cfg_err), '0);
        chk("reset duty", duty, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Basic breath: 2,5,8,8,5,2,2 then done 70 cycles after accept.
        cfg(10, 2, 8, 3, 1, 1, 1, 1);
        build(10, 2, 8, 3, 1, 1, 1, 1);
        run_seq("basic", 1'b1, -1, -1, -1);

        // Saturation at both ends with zero holds.
        cfg(10, 0, 7, 5, 1, 0, 0, 1);
        build(10, 0, 7, 5, 1, 0, 0, 1);
        run_seq("sat", 1'b1, -1, -1, -1);

        // Rejected starts.
        cfg(10, 9, 3, 1, 1, 1, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej minmax cfg_err", W'(cfg_err), W'(1));
        chk("rej minmax busy", W'(busy), '0);
        @(negedge clk);
        chk("rej minmax cfg_err width", W'(cfg_err), '0);
        chk("rej minmax busy later", W'(busy), '0);
        cfg(0, 2, 8, 3, 1, 1, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej period cfg_err", W'(cfg_err), W'(1));
        chk("rej period busy", W'(busy), '0);
        cfg(10, 2, 8, 0, 1, 1, 1, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rej step cfg_err", W'(cfg_err), W'(1));
        chk("rej step busy", W'(busy), '0);
        @(negedge clk);

        // Stop in the middle of FALL (cycle 45 is in the duty=5 falling period).
        cfg(10, 2, 8, 3, 1, 1, 1, 1);
        build(10, 2, 8, 3, 1, 1, 1, 1);
        run_seq("stop", 1'b0, 45, -1, -1);

        // Start and stop together from IDLE: stop wins.
        cfg(10, 2, 8, 3, 1, 1, 1, 1);
        start = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        start = 1'b0;
        stop = 1'b0;
        chk("start+stop cfg_err", W'(cfg_err), '0);
        repeat (3) begin
            chk_idle("start+stop");
            @(negedge clk);
        end

        // Endless run with full duty (duty_max == period), reset mid HOLD_HI of breath 6.
        cfg(4, 1, 4, 2, 1, 2, 1, 0);
        build(4, 1, 4, 2, 1, 2, 1, 6);
        hi_at = -1;
        foreach (exp_st_q[k]) begin
            if (hi_at < 0 && exp_st_q[k] == 5 * 8 + 2) hi_at = k;
        end
        run_seq("endless", 1'b0, -1, -1, hi_at + 1);
        @(negedge clk);
        chk_idle("after rst");

        // Random configurations, with a stray start injected while busy.
        for (int n = 0; n < 10; n++) begin
            per = $urandom_range(1, 8);
            mn  = $urandom_range(0, 6);
            mx  = mn + $urandom_range(0, 6);
            st  = $urandom_range(1, 4);
            dv  = $urandom_range(0, 2);
            hh  = $urandom_range(0, 2);
            hl  = $urandom_range(0, 2);
            rp  = $urandom_range(1, 2);
            cfg(per, mn, mx, st, dv, hh, hl, rp);
            build(per, mn, mx, st, dv, hh, hl, rp);
            run_seq($sformatf("rnd%0d", n), 1'b1, -1, $urandom_range(0, 20), -1);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
